uart_rx_fsm_core: RTL and testbench

// - UART receiver: serial-to-parallel counterpart of the UART TX path. Oversamples rx_in
//   at clk/prescale, qualifies the start bit, deserialises 8 data bits LSB-first,

---
 rtl/uart_rx_defs.sv | 25 ++
 rtl/uart_rx_edge_bit_counter.sv | 37 +++
 rtl/uart_rx_fsm_core.sv | 158 +++++++++++++++
 tb/tb_uart_rx_fsm_core.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_defs.sv
// Shared definitions for the UART receive path: FSM state encodings,
// legal oversampling ratios and parity-type codes.
package uart_rx_defs;

  localparam int DATA_W_DEF  = 8;
  localparam int PRESC_W_DEF = 6;

  // Legal clk-cycles-per-bit values
  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_OUTPUT = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling position tracker: edge_cnt walks 0..prescale-1 inside a bit,
// bit_cnt counts frame bit positions (start bit = 0). Both held at zero while
// disabled so a newly started frame always begins at edge 0 / bit 0.
module uart_rx_edge_bit_counter
  import uart_rx_defs::*;
#(
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int BIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               end_of_bit
);

  assign end_of_bit = en && (edge_cnt == (prescale - PRESC_W'(1)));

  // Advance the edge counter, wrapping into the next bit at prescale-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (end_of_bit) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BIT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fsm_core.sv
// UART receiver core: start-bit qualification, 3-sample majority vote per bit,
// LSB-first deserialisation, optional parity check and stop-bit check.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_in
// START  | timing the start bit; a high vote means a glitch, back to IDLE
// DATA   | shifting in DATA_W bits LSB first
// PARITY | checking the parity bit against the received data
// STOP   | checking the stop bit; results registered at end of bit
// OUTPUT | one-cycle result slot; re-arms straight into START if line is low
module uart_rx_fsm_core
  import uart_rx_defs::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic               par_typ,
  input  logic [PRESC_W-1:0] prescale,
  output logic [DATA_W-1:0]  p_data,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               busy
);

  // Frame is at most start + data + parity + stop bits
  localparam int BIT_W = $clog2(DATA_W + 4);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W);

  rx_state_t          state;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_sel;
  logic [PRESC_W-1:0] half;
  logic               par_en_q;
  logic               par_typ_q;
  logic               par_flag;
  logic [DATA_W-1:0]  shift_reg;
  logic [2:0]         samp;
  logic               bit_sample;
  logic [PRESC_W-1:0] edge_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               end_of_bit;
  logic               cnt_en;

  // An unsupported ratio falls back to 16 rather than producing a degenerate bit time
  assign presc_sel = ((prescale == PRESC_W'(PRESC_8))  ||
                      (prescale == PRESC_W'(PRESC_16)) ||
                      (prescale == PRESC_W'(PRESC_32))) ? prescale : PRESC_W'(PRESC_16);

  assign half   = presc_q >> 1;
  assign cnt_en = (state == ST_START) || (state == ST_DATA) ||
                  (state == ST_PARITY) || (state == ST_STOP);
  assign busy   = (state != ST_IDLE);

  uart_rx_edge_bit_counter #(
    .PRESC_W (PRESC_W),
    .BIT_W   (BIT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (cnt_en),
    .prescale   (presc_q),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .end_of_bit (end_of_bit)
  );

  // Take three samples around mid-bit and register their majority two edges later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp       <= '0;
      bit_sample <= 1'b0;
    end else if (cnt_en) begin
      if (edge_cnt == (half - PRESC_W'(1))) samp[0] <= rx_in;
      if (edge_cnt == half)                 samp[1] <= rx_in;
      if (edge_cnt == (half + PRESC_W'(1))) samp[2] <= rx_in;
      if (edge_cnt == (half + PRESC_W'(2)))
        bit_sample <= (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    end
  end

  // Frame sequencing plus registered result pulses; config is frozen on entry to START
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      presc_q    <= PRESC_W'(PRESC_8);
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      par_flag   <= 1'b0;
      shift_reg  <= '0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_in) begin
            state     <= ST_START;
            presc_q   <= presc_sel;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            par_flag  <= 1'b0;
          end
        end
        ST_START: begin
          if (end_of_bit) state <= bit_sample ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (end_of_bit) begin
            shift_reg <= {bit_sample, shift_reg[DATA_W-1:1]};
            if (bit_cnt == LAST_DATA) state <= par_en_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (end_of_bit) begin
            if (bit_sample != ((^shift_reg) ^ (par_typ_q == PAR_ODD))) begin
              par_err  <= 1'b1;
              par_flag <= 1'b1;
            end
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (end_of_bit) begin
            if (!bit_sample) begin
              stp_err <= 1'b1;
            end else if (!par_flag) begin
              p_data     <= shift_reg;
              data_valid <= 1'b1;
            end
            state <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (!rx_in) begin
            state     <= ST_START;
            presc_q   <= presc_sel;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            par_flag  <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm_core.sv
// Directed bench for uart_rx_fsm_core: frames are driven bit-by-bit and the
// outputs are observed by a negedge monitor that tallies pulses.
module tb_uart_rx_fsm_core;
  import uart_rx_defs::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cnt = 0, ovl_cnt = 0, dv_cyc = 0;
  logic [7:0] dv_last = 8'h00, dv_prev = 8'h00;
  int d0, p0, s0, b0;

  uart_rx_fsm_core #(.DATA_W(8), .PRESC_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt  <= dv_cnt + 1;
      dv_cyc  <= cyc;
      dv_prev <= dv_last;
      dv_last <= p_data;
    end
    if (par_err) pe_cnt <= pe_cnt + 1;
    if (stp_err) se_cnt <= se_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (data_valid && (par_err || stp_err)) ovl_cnt <= ovl_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int p);
    rx_in = b;
    repeat (p) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic ptyp, input logic flip, input logic stopb);
    prescale = 6'(p);
    par_en   = pen;
    par_typ  = ptyp;
    rx_in    = 1'b0;
    start_cyc = cyc;
    repeat (p) tick();
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pen) send_bit((^d) ^ ptyp ^ flip, p);
    send_bit(stopb, p);
    rx_in = 1'b1;
  endtask

  task automatic snap();
    d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt; b0 = busy_cnt;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_p_data", {24'h0, p_data}, 32'h0);
    check("rst_data_valid", {31'h0, data_valid}, 32'h0);
    check("rst_par_err", {31'h0, par_err}, 32'h0);
    check("rst_stp_err", {31'h0, stp_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b1;
    repeat (3) tick();

    // 0x55, P=8, even parity, clean
    snap();
    send_frame(8'h55, 8, 1'b1, PAR_EVEN, 1'b0, 1'b1);
    repeat (4) tick();
    check("f55_dv_count", 32'(dv_cnt - d0), 32'd1);
    check("f55_dv_data", {24'h0, dv_last}, 32'h55);
    check("f55_p_data", {24'h0, p_data}, 32'h55);
    check("f55_par_err", 32'(pe_cnt - p0), 32'd0);
    check("f55_stp_err", 32'(se_cnt - s0), 32'd0);
    check("f55_busy_cycles", 32'(busy_cnt - b0), 32'd89);
    check("f55_latency", 32'(dv_cyc - start_cyc), 32'd89);

    // 0xA3, P=16, odd parity, parity bit flipped
    snap();
    send_frame(8'hA3, 16, 1'b1, PAR_ODD, 1'b1, 1'b1);
    repeat (4) tick();
    check("fa3_par_err", 32'(pe_cnt - p0), 32'd1);
    check("fa3_dv_count", 32'(dv_cnt - d0), 32'd0);
    check("fa3_p_data_hold", {24'h0, p_data}, 32'h55);
    check("fa3_stp_err", 32'(se_cnt - s0), 32'd0);

    // 0x0F, P=32, no parity, stop bit low
    snap();
    send_frame(8'h0F, 32, 1'b0, PAR_EVEN, 1'b0, 1'b0);
    repeat (4) tick();
    check("f0f_stp_err", 32'(se_cnt - s0), 32'd1);
    check("f0f_dv_count", 32'(dv_cnt - d0), 32'd0);
    check("f0f_p_data_hold", {24'h0, p_data}, 32'h55);
    check("f0f_par_err", 32'(pe_cnt - p0), 32'd0);

    // Start-bit glitch: 2 clk low at P=8
    snap();
    prescale = 6'd8;
    par_en = 1'b0;
    rx_in = 1'b0;
    tick();
    tick();
    rx_in = 1'b1;
    repeat (12) tick();
    check("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd8);
    check("glitch_dv", 32'(dv_cnt - d0), 32'd0);
    check("glitch_par_err", 32'(pe_cnt - p0), 32'd0);
    check("glitch_stp_err", 32'(se_cnt - s0), 32'd0);

    // Back-to-back 0x12, 0x34 with no idle gap
    snap();
    send_frame(8'h12, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    send_frame(8'h34, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    repeat (4) tick();
    check("b2b_dv_count", 32'(dv_cnt - d0), 32'd2);
    check("b2b_first", {24'h0, dv_prev}, 32'h12);
    check("b2b_second", {24'h0, dv_last}, 32'h34);

    // Reset mid-DATA of 0xFF, then a clean 0x81
    snap();
    prescale = 6'd8;
    par_en = 1'b0;
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    send_bit(1'b1, 8);
    send_bit(1'b1, 8);
    check("mid_busy_before_rst", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    check("mid_rst_p_data", {24'h0, p_data}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_dv", {31'h0, data_valid}, 32'h0);
    rx_in = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_partial_dv", 32'(dv_cnt - d0), 32'd0);
    send_frame(8'h81, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    repeat (4) tick();
    check("f81_dv_count", 32'(dv_cnt - d0), 32'd1);
    check("f81_p_data", {24'h0, p_data}, 32'h81);

    check("no_err_with_dv", 32'(ovl_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
